// File: rtl/sanduba_pkg.sv
// Shared types and constants for the sanduba customer-side driver.
package sanduba_pkg;

   typedef enum logic [1:0] {
      OpInsert = 2'd0,
      OpBuy    = 2'd1,
      OpRefund = 2'd2
   } op_e;

   typedef enum logic [1:0] {
      ItemGreen = 2'd0,
      ItemAtum  = 2'd1,
      ItemBacon = 2'd2
   } item_e;

   localparam int unsigned PRICE_GREEN = 2;
   localparam int unsigned PRICE_ATUM  = 3;
   localparam int unsigned PRICE_BACON = 4;
   localparam int unsigned CREDIT_MAX  = 32;

   // Unknown items get an unreachable price so they are never vended.
   function automatic logic [5:0] price_of(item_e item);
      logic [5:0] price;
      case (item)
         ItemGreen: price = 6'(PRICE_GREEN);
         ItemAtum:  price = 6'(PRICE_ATUM);
         ItemBacon: price = 6'(PRICE_BACON);
         default:   price = 6'd63;
      endcase
      return price;
   endfunction

endpackage

// File: rtl/sanduba_collector.sv
// SETTLE-phase bookkeeping: quiet/timeout counters, saturating d100 count and sticky item flags.
module sanduba_collector #(
   parameter int unsigned QUIET_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       active,
   input  logic       busy,
   input  logic       d100,
   input  logic       green,
   input  logic       atum,
   input  logic       bacon,
   output logic [5:0] change,
   output logic [2:0] items,
   output logic       settled,
   output logic       timed_out
);

   localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [QW-1:0] quiet_q;
   logic [TW-1:0] timer_q;
   logic [5:0]    change_q;
   logic [2:0]    items_q;
   logic          quiet;

   assign quiet     = !busy && !d100 && !green && !atum && !bacon;
   assign settled   = active && quiet && (quiet_q == QW'(QUIET_CYCLES - 1));
   assign timed_out = active && !settled && (timer_q == TW'(TIMEOUT - 1));
   assign change    = change_q;
   assign items     = items_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         quiet_q  <= '0;
         timer_q  <= '0;
         change_q <= '0;
         items_q  <= '0;
      end else begin
         // Counters restart on every entry into SETTLE.
         if (!active) begin
            quiet_q <= '0;
            timer_q <= '0;
         end else begin
            quiet_q <= quiet ? quiet_q + 1'b1 : '0;
            timer_q <= timer_q + 1'b1;
         end
         if (clear) begin
            change_q <= '0;
            items_q  <= '0;
         end else if (active) begin
            if (d100 && change_q != 6'd63) change_q <= change_q + 6'd1;
            items_q <= items_q | {bacon, atum, green};
         end
      end
   end

endmodule

// File: rtl/sanduba_customer.sv
// Customer-side driver for the sanduba machine: turns commands into request pulses and
// summarises the responses. Define SANDUBA_CUSTOMER_CHECK_EN to add the expected-result model.
module sanduba_customer
   import sanduba_pkg::*;
#(
   parameter int unsigned QUIET_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_item,
   input  logic [5:0] cmd_coins,
   output logic       m100,
   output logic       dev,
   output logic       r_green,
   output logic       r_atum,
   output logic       r_bacon,
   input  logic       d100,
   input  logic       green,
   input  logic       atum,
   input  logic       bacon,
   input  logic       busy,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [5:0] rsp_change,
   output logic [2:0] rsp_items,
   output logic       rsp_timeout,
   output logic       rsp_sat,
   output logic       rsp_mismatch,
   output logic [5:0] credit
);

   typedef enum logic [1:0] {StIdle, StDrive, StSettle, StResp} state_e;

   localparam logic [5:0] CMax = 6'(CREDIT_MAX);

   state_e     state_q, state_d;
   op_e        op_q, op_d;
   item_e      item_q, item_d;
   logic [5:0] coins_q, coins_d;
   logic [5:0] credit_q, credit_d;
   logic       timeout_q, timeout_d;
   logic       sat_q, sat_d;
   logic       clear, accept, settled, timed_out;

   sanduba_collector #(
      .QUIET_CYCLES(QUIET_CYCLES),
      .TIMEOUT     (TIMEOUT)
   ) u_collector (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .active   (state_q == StSettle),
      .busy     (busy),
      .d100     (d100),
      .green    (green),
      .atum     (atum),
      .bacon    (bacon),
      .change   (rsp_change),
      .items    (rsp_items),
      .settled  (settled),
      .timed_out(timed_out)
   );

   assign cmd_ready   = (state_q == StIdle);
   assign rsp_valid   = (state_q == StResp);
   assign accept      = cmd_valid && cmd_ready;
   assign rsp_timeout = timeout_q;
   assign rsp_sat     = sat_q;
   assign credit      = credit_q;

   // Requests are decoded from state and live busy, so they can never overlap a busy cycle.
   always_comb begin
      m100    = 1'b0;
      dev     = 1'b0;
      r_green = 1'b0;
      r_atum  = 1'b0;
      r_bacon = 1'b0;
      if (state_q == StDrive && !busy) begin
         unique case (op_q)
            OpInsert: m100 = 1'b1;
            OpRefund: dev  = 1'b1;
            OpBuy: begin
               r_green = (item_q == ItemGreen);
               r_atum  = (item_q == ItemAtum);
               r_bacon = (item_q == ItemBacon);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      item_d    = item_q;
      coins_d   = coins_q;
      credit_d  = credit_q;
      timeout_d = timeout_q;
      sat_d     = sat_q;
      clear     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               clear     = 1'b1;
               timeout_d = 1'b0;
               sat_d     = 1'b0;
               op_d      = (cmd_op == 2'd3) ? OpRefund : op_e'(cmd_op);
               item_d    = item_e'(cmd_item);
               coins_d   = cmd_coins;
               if (op_d == OpInsert && cmd_coins == 6'd0) begin
                  state_d = StResp;
               end else if (op_d == OpInsert && credit_q == CMax) begin
                  sat_d   = 1'b1;
                  state_d = StResp;
               end else begin
                  state_d = StDrive;
               end
            end
         end
         StDrive: begin
            if (!busy) state_d = StSettle;
         end
         StSettle: begin
            if (settled) begin
               if (op_q == OpInsert) begin
                  credit_d = credit_q + 6'd1;
                  coins_d  = coins_q - 6'd1;
                  if (coins_d == 6'd0) begin
                     state_d = StResp;
                  end else if (credit_d == CMax) begin
                     sat_d   = 1'b1;
                     state_d = StResp;
                  end else begin
                     state_d = StDrive;
                  end
               end else begin
                  credit_d = 6'd0;
                  state_d  = StResp;
               end
            end else if (timed_out) begin
               timeout_d = 1'b1;
               state_d   = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         op_q      <= OpInsert;
         item_q    <= ItemGreen;
         coins_q   <= '0;
         credit_q  <= '0;
         timeout_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         item_q    <= item_d;
         coins_q   <= coins_d;
         credit_q  <= credit_d;
         timeout_q <= timeout_d;
         sat_q     <= sat_d;
      end
   end

`ifdef SANDUBA_CUSTOMER_CHECK_EN
   logic [5:0] exp_change_q, exp_change_d;
   logic [2:0] exp_items_q, exp_items_d;
   logic [5:0] price;

   assign price = price_of(item_d);

   always_comb begin
      exp_change_d = exp_change_q;
      exp_items_d  = exp_items_q;
      if (accept) begin
         exp_change_d = '0;
         exp_items_d  = '0;
         unique case (op_d)
            OpBuy: begin
               if (credit_q >= price) begin
                  exp_change_d = credit_q - price;
                  exp_items_d  = 3'b001 << item_d;
               end else begin
                  exp_change_d = credit_q;
               end
            end
            OpRefund: exp_change_d = credit_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         exp_change_q <= '0;
         exp_items_q  <= '0;
      end else begin
         exp_change_q <= exp_change_d;
         exp_items_q  <= exp_items_d;
      end
   end

   assign rsp_mismatch = rsp_valid &&
                         ((rsp_change != exp_change_q) || (rsp_items != exp_items_q));
`else
   assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sanduba_customer.sv
// Directed, table-driven bench for sanduba_customer with a small behavioural machine model.
module tb_sanduba_customer;
   import sanduba_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op, cmd_item;
   logic [5:0] cmd_coins;
   logic       m100, dev, r_green, r_atum, r_bacon;
   logic       d100, green, atum, bacon, busy;
   logic       rsp_valid, rsp_ready;
   logic [5:0] rsp_change, credit;
   logic [2:0] rsp_items;
   logic       rsp_timeout, rsp_sat, rsp_mismatch;

   int n_vec = 0;
   int n_err = 0;
   int n_req = 0;
   int n_viol = 0;
   int hang_len = 1;
   int m_credit, m_change, m_hang;
   logic [2:0] m_item;

   always #5 clock = ~clock;

   sanduba_customer dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_item    (cmd_item),
      .cmd_coins   (cmd_coins),
      .m100        (m100),
      .dev         (dev),
      .r_green     (r_green),
      .r_atum      (r_atum),
      .r_bacon     (r_bacon),
      .d100        (d100),
      .green       (green),
      .atum        (atum),
      .bacon       (bacon),
      .busy        (busy),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_change  (rsp_change),
      .rsp_items   (rsp_items),
      .rsp_timeout (rsp_timeout),
      .rsp_sat     (rsp_sat),
      .rsp_mismatch(rsp_mismatch),
      .credit      (credit)
   );

   function automatic int price_req(logic g, logic a, logic b);
      return g ? 2 : (a ? 3 : (b ? 4 : 99));
   endfunction

   // Machine model: busy for hang_len cycles after a request, then item pulse, then change.
   always @(posedge clock) begin
      d100  <= 1'b0;
      green <= 1'b0;
      atum  <= 1'b0;
      bacon <= 1'b0;
      if (reset) begin
         busy     <= 1'b0;
         m_credit <= 0;
         m_change <= 0;
         m_hang   <= 0;
         m_item   <= '0;
      end else if (m_hang > 0) begin
         m_hang <= m_hang - 1;
         busy   <= (m_hang > 1) || (m_item != 0) || (m_change > 0);
      end else if (m_item != 0) begin
         {bacon, atum, green} <= m_item;
         m_item <= '0;
         busy   <= (m_change > 0);
      end else if (m_change > 0) begin
         d100     <= 1'b1;
         m_change <= m_change - 1;
         busy     <= (m_change > 1);
      end else begin
         busy <= 1'b0;
         if (m100 | dev | r_green | r_atum | r_bacon) begin
            busy   <= 1'b1;
            m_hang <= hang_len;
         end
         if (m100) m_credit <= m_credit + 1;
         if (dev) begin
            m_change <= m_credit;
            m_credit <= 0;
         end
         if (r_green | r_atum | r_bacon) begin
            if (m_credit >= price_req(r_green, r_atum, r_bacon)) begin
               m_item   <= {r_bacon, r_atum, r_green};
               m_change <= m_credit - price_req(r_green, r_atum, r_bacon);
            end else begin
               m_change <= m_credit;
            end
            m_credit <= 0;
         end
      end
   end

   always @(posedge clock) begin
      if (!reset) begin
         if (m100 | dev | r_green | r_atum | r_bacon) n_req <= n_req + 1;
         if (busy && (m100 | dev | r_green | r_atum | r_bacon)) n_viol <= n_viol + 1;
         if ($countones({m100, dev, r_green, r_atum, r_bacon}) > 1) n_viol <= n_viol + 1;
      end
   end

   typedef struct {
      logic [1:0] op;
      logic [1:0] item;
      logic [5:0] coins;
      int         hang;
      int         pulses;
      logic [5:0] change;
      logic [2:0] items;
      logic       tmo;
      logic       sat;
      logic [5:0] credit;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   start;
      logic got;
      @(negedge clock);
      hang_len  = v.hang;
      check($sformatf("v%0d.cmd_ready", idx), cmd_ready, 1);
      start     = n_req;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_item  = v.item;
      cmd_coins = v.coins;
      @(negedge clock);
      cmd_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check($sformatf("v%0d.rsp_arrived", idx), got, 1);
      check($sformatf("v%0d.ready_during_rsp", idx), cmd_ready, 0);
      check($sformatf("v%0d.change", idx), rsp_change, v.change);
      check($sformatf("v%0d.items", idx), rsp_items, v.items);
      check($sformatf("v%0d.timeout", idx), rsp_timeout, v.tmo);
      check($sformatf("v%0d.sat", idx), rsp_sat, v.sat);
      check($sformatf("v%0d.mismatch", idx), rsp_mismatch, 0);
      check($sformatf("v%0d.credit", idx), credit, v.credit);
      repeat (2) @(negedge clock);
      check($sformatf("v%0d.rsp_held", idx), rsp_valid, 1);
      check($sformatf("v%0d.change_held", idx), rsp_change, v.change);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      hang_len  = 1;
      check($sformatf("v%0d.idle_after_ack", idx), cmd_ready, 1);
      check($sformatf("v%0d.pulses", idx), n_req - start, v.pulses);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".cmd_ready"}, cmd_ready, 1);
      check({tag, ".rsp_valid"}, rsp_valid, 0);
      check({tag, ".credit"}, credit, 0);
      check({tag, ".requests"}, {m100, dev, r_green, r_atum, r_bacon}, 0);
      check({tag, ".rsp_fields"}, {rsp_change, rsp_items, rsp_timeout, rsp_sat, rsp_mismatch}, 0);
   endtask

   initial begin
      logic seen;
      //           op        item       coins hang pulses chg   items   tmo   sat   credit
      vecs[0]  = '{OpInsert, ItemGreen, 6'd3,  1,   3,    6'd0,  3'b000, 1'b0, 1'b0, 6'd3};
      vecs[1]  = '{OpInsert, ItemGreen, 6'd2,  1,   2,    6'd0,  3'b000, 1'b0, 1'b0, 6'd5};
      vecs[2]  = '{OpBuy,    ItemAtum,  6'd0,  1,   1,    6'd2,  3'b010, 1'b0, 1'b0, 6'd0};
      vecs[3]  = '{OpInsert, ItemGreen, 6'd1,  1,   1,    6'd0,  3'b000, 1'b0, 1'b0, 6'd1};
      vecs[4]  = '{OpBuy,    ItemBacon, 6'd0,  1,   1,    6'd1,  3'b000, 1'b0, 1'b0, 6'd0};
      vecs[5]  = '{OpInsert, ItemGreen, 6'd0,  1,   0,    6'd0,  3'b000, 1'b0, 1'b0, 6'd0};
      vecs[6]  = '{OpBuy,    ItemGreen, 6'd0,  1,   1,    6'd0,  3'b000, 1'b0, 1'b0, 6'd0};
      vecs[7]  = '{OpInsert, ItemGreen, 6'd40, 1,   32,   6'd0,  3'b000, 1'b0, 1'b1, 6'd32};
      vecs[8]  = '{OpInsert, ItemGreen, 6'd2,  1,   0,    6'd0,  3'b000, 1'b0, 1'b1, 6'd32};
      vecs[9]  = '{OpRefund, ItemGreen, 6'd0,  1,   1,    6'd32, 3'b000, 1'b0, 1'b0, 6'd0};
      vecs[10] = '{OpInsert, ItemGreen, 6'd2,  1,   2,    6'd0,  3'b000, 1'b0, 1'b0, 6'd2};
      vecs[11] = '{OpBuy,    ItemGreen, 6'd0,  1,   1,    6'd0,  3'b001, 1'b0, 1'b0, 6'd0};
      vecs[12] = '{OpInsert, ItemGreen, 6'd1,  100, 1,    6'd0,  3'b000, 1'b1, 1'b0, 6'd0};
      // Machine is still busy from the hang: the request must wait it out.
      vecs[13] = '{OpInsert, ItemGreen, 6'd1,  1,   1,    6'd0,  3'b000, 1'b0, 1'b0, 6'd1};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_item  = '0;
      cmd_coins = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_state("por");
      reset = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Reset in the middle of a BUY settle.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      run_vec('{OpInsert, ItemGreen, 6'd4, 1, 4, 6'd0, 3'b000, 1'b0, 1'b0, 6'd4}, 14);
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op    = OpBuy;
      cmd_item  = ItemGreen;
      @(negedge clock);
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (r_green) begin
            seen = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("midreset.r_green_seen", seen, 1);
      @(negedge clock);
      check("midreset.in_flight", {cmd_ready, rsp_valid}, 2'b00);
      reset = 1'b1;
      @(negedge clock);
      check_reset_state("midreset");
      reset = 1'b0;
      run_vec('{OpRefund, ItemGreen, 6'd0, 1, 1, 6'd0, 3'b000, 1'b0, 1'b0, 6'd0}, 15);

      check("no_req_while_busy", n_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sanduba_customer.md
Name: sanduba_customer

Overview:
- Customer-side driver for the sanduba vending interface: the initiator that feeds the sanduba machine.
- Turns high-level commands (insert N coins, buy an item, request a refund) into single-cycle pulses on m100/dev/r_green/r_atum/r_bacon, honouring busy.
- Collects the machine's d100/green/atum/bacon responses and returns a per-command summary.
- Used as the stimulus/consumer end in simulation benches and formal environments, and as the front-panel controller in top-level builds.

Parameters:
- QUIET_CYCLES, 2: consecutive busy-low cycles that mark a transaction settled.
- TIMEOUT, 64: max cycles in SETTLE before the transaction is aborted.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when valid&&ready.
- cmd_op  in  2  op_e: INSERT, BUY, REFUND.
- cmd_item  in  2  item_e: GREEN, ATUM, BACON (BUY only).
- cmd_coins  in  6  coins to insert (INSERT only).
- m100, dev, r_green, r_atum, r_bacon  out  1 each  one-cycle request pulses to the machine.
- d100, green, atum, bacon, busy  in  1 each  machine outputs.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_change  out  6  d100 pulses counted, saturating at 63.
- rsp_items  out  3  sticky {bacon,atum,green} seen.
- rsp_timeout  out  1  SETTLE exceeded TIMEOUT.
- rsp_sat  out  1  INSERT stopped at CREDIT_MAX.
- rsp_mismatch  out  1  result differs from model.
- credit  out  6  current believed machine credit.

Behaviour:
- Reset:
  - All outputs 0, credit 0, FSM to IDLE.
  - Reset mid-transaction drops the in-flight command and any pending response.
- FSM states: IDLE -> DRIVE -> SETTLE -> (DRIVE | RESP) -> IDLE.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On accept: latch op, item and coins; clear the collection counters.
  - INSERT with coins=0 goes directly to RESP.
- DRIVE:
  - Waits while busy=1.
  - On the first cycle with busy=0, registers exactly one request pulse (m100, dev or r_<item>) for one cycle, then goes to SETTLE.
  - Request outputs are $onehot0 at all times and never high in a cycle where busy was sampled 1.
- SETTLE:
  - Counts d100 and ORs green/atum/bacon into rsp_items every cycle, including cycles with simultaneous events.
  - Exits after QUIET_CYCLES consecutive busy=0 cycles with no machine output.
  - Reaching TIMEOUT goes to RESP with rsp_timeout=1; remaining coins are abandoned.
- INSERT:
  - Each completed coin increments credit.
  - If coins remain and credit<CREDIT_MAX, return to DRIVE.
  - If credit==CREDIT_MAX with coins remaining, go to RESP with rsp_sat=1.
- BUY/REFUND: after settling, credit=0 (the machine returns all remaining funds); go to RESP.
- RESP:
  - rsp_valid=1; rsp fields stable until rsp_valid&&rsp_ready, then IDLE.
  - rsp_valid and cmd_ready are never high together.
- Arithmetic: credit and the d100 counter are 6-bit; the counter saturates at 63, credit never exceeds CREDIT_MAX (32).

Optional Feature:
- Macro: SANDUBA_CUSTOMER_CHECK_EN.
- Defined: an expected-result model computes at command accept.
  - BUY with credit>=price: item expected, change = credit-price.
  - BUY with credit<price: no item, change = credit.
  - REFUND: change = credit.
  - INSERT: change 0, no item.
  - rsp_mismatch=1 if rsp_change or rsp_items differ from the model.
- Undefined: rsp_mismatch tied 0; no model logic synthesised.

Decomposition:
- sanduba_pkg:
  - op_e and item_e enums.
  - Prices PRICE_GREEN=2, PRICE_ATUM=3, PRICE_BACON=4.
  - CREDIT_MAX=32.
  - price_of(item_e) function.
- Sub-module sanduba_collector: SETTLE-phase quiet/timeout counters, saturating d100 counter and sticky item flags, with a clear input driven from the main FSM.

Test Plan:
- INSERT 3 with the machine idle -> three m100 pulses separated by settle periods, credit=3, rsp_change=0, rsp_items=000.
- After INSERT 5, BUY ATUM -> one r_atum pulse, rsp_items=010, rsp_change=2, credit=0, rsp_mismatch=0.
- After INSERT 1, BUY BACON -> no item, rsp_change=1, rsp_items=000.
- INSERT 40 from credit 0 -> 32 m100 pulses, rsp_sat=1, credit=32; then REFUND -> rsp_change=32.
- busy held high for 100 cycles after a pulse -> rsp_timeout=1 at TIMEOUT; no request pulses ever asserted while busy=1.
- reset asserted during SETTLE of a BUY -> next cycle all outputs 0, credit=0, cmd_ready=1, no rsp_valid.
